alu_acc_mc: RTL and testbench
=============================

// Module: alu_acc_mc
// PURPOSE
//  Parametrised accumulator ALU; successor to the fixed 16-bit one-hot-control accumulator.
//  Takes an encoded opcode plus operand over a valid/ready handshake. Holds ACC and a HI/remainder register.
//  Single-cycle add/sub/logic/shift ops. Iterative multi-cycle MUL/DIV. Five result flags. Pulses done per op.
//  Sits between the controller/microsequencer and the BR operand bus; ACC drives the datapath result bus.
// PARAMETERS
//  WIDTH     16   datapath width of ACC, HI and operand (>=4)
//  SHAMT_W   $clog2(WIDTH)  derived localparam, shift-amount bits taken from operand
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  op_valid   in   1        opcode+operand presented
//  op_ready   out  1        block can accept an op this cycle
//  opcode     in   4        operation, encoding from alu_acc_pkg
//  operand    in   WIDTH    BR value
//  acc_out    out  WIDTH    ACC register
//  hi_out     out  WIDTH    MUL high half / DIV remainder
//  flags      out  5        {ZF,CF,OF,SF,DZ}, registered
//  done       out  1        one-cycle pulse: op result written
//  busy       out  1        multi-cycle op in progress
// BEHAVIOUR
//  Reset (async, any state): ACC=0, HI=0, flags=0, done=0, busy=0, op_ready=1, FSM=IDLE, in-flight op dropped.
//  Accept: op_valid&&op_ready at rising edge. op_ready = (state==IDLE). opcode/operand sampled only at accept.
//  Opcodes: 0 NOP, 1 CLR, 2 LOAD, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 SHL, 8 SHR, 9 AND, 10 OR, 11 NOT, 12 XOR.
//    12..15 other than XOR (13-15) act as NOP.
//  Single-cycle ops: ACC and flags are written on the accept edge. done=1 in the following cycle. FSM stays IDLE.
//  Back-to-back single-cycle ops are accepted every cycle; each uses the ACC written by the previous op.
//  NOP: ACC, HI and flags unchanged; done still pulses.
//  CLR: ACC=0, HI=0. LOAD: ACC=operand. NOT: ACC=~operand. AND/OR/XOR: ACC op operand.
//  Flags, general rule: computed from the NEW result, never from the old ACC.
//    ZF = (result==0); SF = result[WIDTH-1].
//    CF, OF and DZ are 0 unless the op defines them below.
//  ADD: (WIDTH+1)-bit sum. CF = carry out. OF = signed overflow (same operand signs, result sign differs).
//  SUB: ACC-operand. CF = borrow (ACC<operand unsigned). OF = signed overflow (operand signs differ, result sign != ACC sign).
//  SHL/SHR: logical shift by s = operand[SHAMT_W-1:0].
//    CF = last bit shifted out; s==0 gives CF=0 and ACC unchanged.
//  MUL: unsigned, {HI,ACC} = ACC*operand.
//    FSM IDLE->MUL: exactly WIDTH shift-add iterations, one per cycle.
//    Result written on the edge after the last iteration; done pulses the next cycle.
//    Accept-to-done latency = WIDTH+1 cycles. CF=OF=(HI!=0). ZF/SF from ACC (low half).
//  DIV: unsigned restoring division. ACC = ACC/operand, HI = ACC%operand. Same WIDTH-iteration timing as MUL.
//    Divide by zero: detected at accept, no iterations. ACC={WIDTH{1}}, HI=old ACC, DZ=1. done next cycle.
//  FSM states: IDLE, MUL, DIV. Iteration counter is SHAMT_W+1 bits, loaded with WIDTH-1 at accept.
//    Last iteration when counter==0; then ->IDLE.
//    busy=1 and op_ready=0 in MUL/DIV. ACC, HI and flags are held stable until the final write.
//  op_valid is ignored while busy; the source must hold it (standard valid/ready, no drop).
//  done never asserts twice for one op. Reset asserted mid-MUL/DIV: no done, no partial result.
// STRUCTURE
//  alu_acc_pkg: opcode localparams/enum, flag bit indices (FLG_ZF=4..FLG_DZ=0), FSM state encoding.
//  Sub-module alu_acc_muldiv: iterative shift-add / restoring-divide core.
//    Interface: start, is_div, a, b, result_lo, result_hi, last.
//    Top level owns the handshake, FSM, ACC/HI/flags registers and the single-cycle ops.
// TESTING  (WIDTH=16 unless noted)
//  Reset mid-MUL: LOAD 3, MUL 5, assert rst_n=0 at iteration 7 -> ACC=0, HI=0, flags=0, no done, op_ready=1.
//  LOAD 0xFFFF, ADD 1 -> ACC=0x0000, ZF=1, CF=1, OF=0. LOAD 0x7FFF, ADD 1 -> ACC=0x8000, OF=1, SF=1, CF=0.
//  LOAD 5, SUB 7 -> ACC=0xFFFE, CF=1, SF=1. LOAD 0x8000, SUB 1 -> ACC=0x7FFF, OF=1.
//  LOAD 0x1234, MUL 0x0100 -> done exactly 17 cycles after accept, ACC=0x3400, HI=0x0012, CF=OF=1.
//    op_ready=0 during the iterations.
//  LOAD 100, DIV 7 -> ACC=14, HI=2, 17-cycle latency. LOAD 9, DIV 0 -> ACC=0xFFFF, HI=9, DZ=1, done next cycle.
//  LOAD 0x8001, SHL 1 -> ACC=0x0002, CF=1. SHR 0 -> ACC unchanged, CF=0.
//    Back-to-back LOAD/AND/OR/XOR/NOT, one per cycle -> done every cycle, values match the model.

Source files
------------

// File: rtl/alu_acc_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the accumulator ALU.
package alu_acc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_CLR  = 4'd1,
        OP_LOAD = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_MUL  = 4'd5,
        OP_DIV  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_AND  = 4'd9,
        OP_OR   = 4'd10,
        OP_NOT  = 4'd11,
        OP_XOR  = 4'd12
    } opcode_e;

    localparam int FLG_ZF    = 4;
    localparam int FLG_CF    = 3;
    localparam int FLG_OF    = 2;
    localparam int FLG_SF    = 1;
    localparam int FLG_DZ    = 0;
    localparam int NUM_FLAGS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic zf, input logic cf,
                                                        input logic of, input logic sf,
                                                        input logic dz);
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLG_ZF] = zf;
        f[FLG_CF] = cf;
        f[FLG_OF] = of;
        f[FLG_SF] = sf;
        f[FLG_DZ] = dz;
        return f;
    endfunction

endpackage

// File: rtl/alu_acc_muldiv.sv
// Iterative core: WIDTH-step shift-add multiply or restoring divide, one step per cycle.
// result_lo/result_hi show the value after the current step, so the caller latches them when last=1.
module alu_acc_muldiv
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
    logic             div_reg, active_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff, hi_next, lo_next;

    // lo_reg holds the multiplier (MUL) or the dividend/quotient (DIV); hi_reg is the partial product or remainder.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - b_reg;
        if (div_reg) begin
            if (div_shift >= {1'b0, b_reg}) begin
                hi_next = div_diff;
                lo_next = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_shift[WIDTH-1:0];
                lo_next = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            div_reg    <= 1'b0;
            active_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (start) begin
            hi_reg     <= '0;
            lo_reg     <= a;
            b_reg      <= b;
            div_reg    <= is_div;
            active_reg <= 1'b1;
            cnt_reg    <= CNT_W'(WIDTH - 1);
        end else if (active_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                active_reg <= 1'b0;
            end
        end
    end

    assign result_lo = lo_next;
    assign result_hi = hi_next;
    assign last      = active_reg && (cnt_reg == '0);

endmodule

// File: rtl/alu_acc_mc.sv
// Accumulator ALU with valid/ready op intake, single-cycle arithmetic/logic/shift ops
// and iterative MUL/DIV; ACC, HI and flags are registered and done pulses once per op.
module alu_acc_mc
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     operand,
    output logic [WIDTH-1:0]     acc_out,
    output logic [WIDTH-1:0]     hi_out,
    output logic [NUM_FLAGS-1:0] flags,
    output logic                 done,
    output logic                 busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_e               state_reg;
    logic [WIDTH-1:0]     acc_reg, hi_reg;
    logic [NUM_FLAGS-1:0] flags_reg;
    logic                 done_reg;

    logic                 accept, md_start, md_is_div, md_last;
    logic [WIDTH-1:0]     md_lo, md_hi;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH:0]       sum_ext, diff_ext, shl_ext, shr_ext;
    logic [WIDTH-1:0]     sc_acc, sc_hi;
    logic                 sc_cf, sc_of, sc_dz, sc_flag_wr;
    logic [NUM_FLAGS-1:0] sc_flags, md_flags;

    assign op_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign shamt     = operand[SHAMT_W-1:0];
    assign md_is_div = (opcode == OP_DIV);
    // A zero divisor is resolved immediately and never enters the iterative core.
    assign md_start  = accept && ((opcode == OP_MUL) || ((opcode == OP_DIV) && (operand != '0)));

    always_comb begin
        sum_ext    = {1'b0, acc_reg} + {1'b0, operand};
        diff_ext   = {1'b0, acc_reg} - {1'b0, operand};
        shl_ext    = {1'b0, acc_reg} << shamt;
        shr_ext    = {acc_reg, 1'b0} >> shamt;
        sc_acc     = acc_reg;
        sc_hi      = hi_reg;
        sc_cf      = 1'b0;
        sc_of      = 1'b0;
        sc_dz      = 1'b0;
        sc_flag_wr = 1'b1;
        case (opcode)
            OP_CLR: begin
                sc_acc = '0;
                sc_hi  = '0;
            end
            OP_LOAD: sc_acc = operand;
            OP_ADD: begin
                sc_acc = sum_ext[WIDTH-1:0];
                sc_cf  = sum_ext[WIDTH];
                sc_of  = (acc_reg[WIDTH-1] == operand[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != acc_reg[WIDTH-1]);
            end
            OP_SUB: begin
                sc_acc = diff_ext[WIDTH-1:0];
                sc_cf  = diff_ext[WIDTH];
                sc_of  = (acc_reg[WIDTH-1] != operand[WIDTH-1]) &&
                         (diff_ext[WIDTH-1] != acc_reg[WIDTH-1]);
            end
            OP_DIV: begin
                sc_acc = '1;
                sc_hi  = acc_reg;
                sc_dz  = 1'b1;
            end
            OP_SHL: begin
                sc_acc = shl_ext[WIDTH-1:0];
                sc_cf  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                sc_acc = shr_ext[WIDTH:1];
                sc_cf  = shr_ext[0];
            end
            OP_AND:  sc_acc = acc_reg & operand;
            OP_OR:   sc_acc = acc_reg | operand;
            OP_NOT:  sc_acc = ~operand;
            OP_XOR:  sc_acc = acc_reg ^ operand;
            default: sc_flag_wr = 1'b0;
        endcase
        sc_flags = pack_flags(sc_acc == '0, sc_cf, sc_of, sc_acc[WIDTH-1], sc_dz);
        md_flags = pack_flags(md_lo == '0, (state_reg == ST_MUL) && (md_hi != '0),
                              (state_reg == ST_MUL) && (md_hi != '0), md_lo[WIDTH-1], 1'b0);
    end

    alu_acc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (md_is_div),
        .a         (acc_reg),
        .b         (operand),
        .result_lo (md_lo),
        .result_hi (md_hi),
        .last      (md_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            hi_reg    <= '0;
            flags_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (md_start) begin
                        state_reg <= md_is_div ? ST_DIV : ST_MUL;
                    end else if (accept) begin
                        acc_reg  <= sc_acc;
                        hi_reg   <= sc_hi;
                        done_reg <= 1'b1;
                        if (sc_flag_wr) begin
                            flags_reg <= sc_flags;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_last) begin
                        acc_reg   <= md_lo;
                        hi_reg    <= md_hi;
                        flags_reg <= md_flags;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign acc_out = acc_reg;
    assign hi_out  = hi_reg;
    assign flags   = flags_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_alu_acc_mc.sv
// Bench for alu_acc_mc: vector table plus random model-driven ops feed a scoreboard
// that is checked on every done pulse; hand sequence covers reset during MUL.
module tb_alu_acc_mc;
    import alu_acc_pkg::*;

    logic        clk, rst_n, op_valid, op_ready, done, busy;
    logic [3:0]  opcode;
    logic [15:0] operand, acc_out, hi_out;
    logic [4:0]  flags;

    alu_acc_mc #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .operand  (operand),
        .acc_out  (acc_out),
        .hi_out   (hi_out),
        .flags    (flags),
        .done     (done),
        .busy     (busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] opd;
        logic [15:0] acc;
        logic [15:0] hi;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] acc;
        logic [15:0] hi;
        logic [4:0]  fl;
        int          lat;
        int          acc_cyc;
        int          idx;
    } exp_t;

    typedef struct packed {
        logic [15:0] acc;
        logic [15:0] hi;
        logic [4:0]  fl;
    } st_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vecs[0:28];
    st_t  mst;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s op#%0d got=%h want=%h", name, idx, act, want);
        end
    endtask

    // Independent reference: plain arithmetic operators, 16-bit datapath.
    function automatic st_t model(input st_t s, input logic [3:0] op, input logic [15:0] opd);
        st_t         r;
        logic        cf, of, dz, upd;
        logic [31:0] p;
        int          sh;
        r = s; cf = 0; of = 0; dz = 0; upd = 1; sh = int'(opd[3:0]);
        case (op)
            4'd1: begin r.acc = 0; r.hi = 0; end
            4'd2: r.acc = opd;
            4'd3: begin
                {cf, r.acc} = {1'b0, s.acc} + {1'b0, opd};
                of = (s.acc[15] == opd[15]) && (r.acc[15] != s.acc[15]);
            end
            4'd4: begin
                r.acc = s.acc - opd;
                cf = (s.acc < opd);
                of = (s.acc[15] != opd[15]) && (r.acc[15] != s.acc[15]);
            end
            4'd5: begin
                p = 32'(s.acc) * 32'(opd);
                r.acc = p[15:0]; r.hi = p[31:16];
                cf = (r.hi != 0); of = cf;
            end
            4'd6: begin
                if (opd == 0) begin r.acc = 16'hFFFF; r.hi = s.acc; dz = 1; end
                else begin r.acc = s.acc / opd; r.hi = s.acc % opd; end
            end
            4'd7: begin r.acc = s.acc << sh; cf = (sh != 0) ? s.acc[16 - sh] : 1'b0; end
            4'd8: begin r.acc = s.acc >> sh; cf = (sh != 0) ? s.acc[sh - 1] : 1'b0; end
            4'd9:  r.acc = s.acc & opd;
            4'd10: r.acc = s.acc | opd;
            4'd11: r.acc = ~opd;
            4'd12: r.acc = s.acc ^ opd;
            default: upd = 0;
        endcase
        if (upd) r.fl = {r.acc == 0, cf, of, r.acc[15], dz};
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with op_valid low.
    task automatic send(input logic [3:0] op, input logic [15:0] opd, input bit push,
                        input logic [15:0] eacc, input logic [15:0] ehi, input logic [4:0] efl,
                        input int elat, input int idx);
        int   waits = 0;
        exp_t e;
        op_valid = 1; opcode = op; operand = opd;
        while (!op_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!op_ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout op#%0d got=op_ready=0 want=1", idx);
            op_valid = 0;
            return;
        end
        if (push) begin
            e.acc = eacc; e.hi = ehi; e.fl = efl; e.lat = elat; e.acc_cyc = cyc + 1; e.idx = idx;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        op_valid = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL done_unexpected got=done=1 want=0 cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("acc", e.idx, 32'(acc_out), 32'(e.acc));
                chk("hi", e.idx, 32'(hi_out), 32'(e.hi));
                chk("flags", e.idx, 32'(flags), 32'(e.fl));
                chk("latency", e.idx, 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
            end
        end
    end

    task automatic drain(input int idx);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", idx, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        clk = 0; rst_n = 0; op_valid = 0; opcode = 0; operand = 0;
        //            op       opd       acc       hi        flags     lat
        vecs[0]  = '{OP_LOAD, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b00010, 1};
        vecs[1]  = '{OP_ADD,  16'h0001, 16'h0000, 16'h0000, 5'b11000, 1};
        vecs[2]  = '{OP_LOAD, 16'h7FFF, 16'h7FFF, 16'h0000, 5'b00000, 1};
        vecs[3]  = '{OP_ADD,  16'h0001, 16'h8000, 16'h0000, 5'b00110, 1};
        vecs[4]  = '{OP_LOAD, 16'h0005, 16'h0005, 16'h0000, 5'b00000, 1};
        vecs[5]  = '{OP_SUB,  16'h0007, 16'hFFFE, 16'h0000, 5'b01010, 1};
        vecs[6]  = '{OP_LOAD, 16'h8000, 16'h8000, 16'h0000, 5'b00010, 1};
        vecs[7]  = '{OP_SUB,  16'h0001, 16'h7FFF, 16'h0000, 5'b00100, 1};
        vecs[8]  = '{OP_LOAD, 16'h1234, 16'h1234, 16'h0000, 5'b00000, 1};
        vecs[9]  = '{OP_MUL,  16'h0100, 16'h3400, 16'h0012, 5'b01100, 17};
        vecs[10] = '{OP_LOAD, 16'd100,  16'd100,  16'h0012, 5'b00000, 1};
        vecs[11] = '{OP_DIV,  16'd7,    16'd14,   16'd2,    5'b00000, 17};
        vecs[12] = '{OP_LOAD, 16'd9,    16'd9,    16'd2,    5'b00000, 1};
        vecs[13] = '{OP_DIV,  16'd0,    16'hFFFF, 16'd9,    5'b00011, 1};
        vecs[14] = '{OP_LOAD, 16'h8001, 16'h8001, 16'd9,    5'b00010, 1};
        vecs[15] = '{OP_SHL,  16'h0001, 16'h0002, 16'd9,    5'b01000, 1};
        vecs[16] = '{4'd13,   16'h1234, 16'h0002, 16'd9,    5'b01000, 1};
        vecs[17] = '{OP_SHR,  16'h0000, 16'h0002, 16'd9,    5'b00000, 1};
        vecs[18] = '{OP_CLR,  16'h5555, 16'h0000, 16'h0000, 5'b10000, 1};
        vecs[19] = '{OP_LOAD, 16'h00F0, 16'h00F0, 16'h0000, 5'b00000, 1};
        vecs[20] = '{OP_SHR,  16'h0005, 16'h0007, 16'h0000, 5'b01000, 1};
        vecs[21] = '{OP_LOAD, 16'h0003, 16'h0003, 16'h0000, 5'b00000, 1};
        vecs[22] = '{OP_SHL,  16'h000F, 16'h8000, 16'h0000, 5'b01010, 1};
        vecs[23] = '{OP_MUL,  16'hFFFF, 16'h8000, 16'h7FFF, 5'b01110, 17};
        vecs[24] = '{OP_NOT,  16'h00FF, 16'hFF00, 16'h7FFF, 5'b00010, 1};
        vecs[25] = '{OP_AND,  16'h0F0F, 16'h0F00, 16'h7FFF, 5'b00000, 1};
        vecs[26] = '{OP_OR,   16'h00F0, 16'h0FF0, 16'h7FFF, 5'b00000, 1};
        vecs[27] = '{OP_XOR,  16'h0FF0, 16'h0000, 16'h7FFF, 5'b10000, 1};
        vecs[28] = '{OP_NOP,  16'hFFFF, 16'h0000, 16'h7FFF, 5'b10000, 1};

        repeat (3) @(negedge clk);
        chk("rst_acc", -1, 32'(acc_out), 32'd0);
        chk("rst_hi", -1, 32'(hi_out), 32'd0);
        chk("rst_flags", -1, 32'(flags), 32'd0);
        chk("rst_done", -1, 32'(done), 32'd0);
        chk("rst_busy", -1, 32'(busy), 32'd0);
        chk("rst_ready", -1, 32'(op_ready), 32'd1);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i <= 28; i++)
            send(vecs[i].op, vecs[i].opd, 1, vecs[i].acc, vecs[i].hi, vecs[i].fl, vecs[i].lat, i);
        drain(29);

        mst = '{acc: 16'h0000, hi: 16'h7FFF, fl: 5'b10000};
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [15:0] opd;
            st_t         nst;
            op  = 4'($urandom_range(0, 15));
            opd = (i % 4 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            nst = model(mst, op, opd);
            send(op, opd, 1, nst.acc, nst.hi, nst.fl,
                 ((op == 4'd5) || (op == 4'd6 && opd != 0)) ? 17 : 1, 100 + i);
            mst = nst;
        end
        drain(160);

        // Reset mid-MUL: no done, no partial result, ready again at once.
        mst = model(mst, OP_LOAD, 16'd3);
        send(OP_LOAD, 16'd3, 1, mst.acc, mst.hi, mst.fl, 1, 200);
        send(OP_MUL, 16'd5, 0, 16'd0, 16'd0, 5'd0, 0, 201);
        for (int k = 0; k < 7; k++) begin
            chk("mul_ready_low", 201, 32'(op_ready), 32'd0);
            chk("mul_busy", 201, 32'(busy), 32'd1);
            @(negedge clk);
        end
        rst_n = 0;
        #1;
        chk("midrst_acc", 201, 32'(acc_out), 32'd0);
        chk("midrst_hi", 201, 32'(hi_out), 32'd0);
        chk("midrst_flags", 201, 32'(flags), 32'd0);
        chk("midrst_done", 201, 32'(done), 32'd0);
        chk("midrst_ready", 201, 32'(op_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        send(OP_LOAD, 16'h00AA, 1, 16'h00AA, 16'h0000, 5'b00000, 1, 202);
        drain(203);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
